alu: RTL and testbench

//  16-bit datapath ALU for the processor core: add, subtract, address-style add (LOAD/STR) and multiply.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_if.sv | 13 +
 rtl/alu_karatsuba_mul.sv | 142 ++++++++++++++
 rtl/alu.sv | 59 +++++
 tb/tb_alu.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encodings and the Karatsuba multiplier state enum.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_STR  = 3'b101;

    typedef enum logic [2:0] {
        KS_IDLE,
        KS_LOAD,
        KS_Z02,
        KS_Z1,
        KS_COMB,
        KS_DONE
    } kar_state_t;

endpackage

// File: rtl/alu_if.sv
// Operation request/result bundle between the core and the ALU.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;

    modport master (output start, output opcode, output a, output b, input result);
    modport slave  (input start, input opcode, input a, input b, output result);
endinterface

// File: rtl/alu_karatsuba_mul.sv
// Iterative Karatsuba multiplier: two half-width shift-add units for z0/z2,
// one (WIDTH/2+1)-bit shift-add for the middle term, then a single combine step.
module karatsuba_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] prod,
    output logic               done,
    output logic               busy
);
    localparam int HALF  = WIDTH / 2;
    localparam int SW    = HALF + 1;
    localparam int PW    = WIDTH + 2;
    localparam int PRODW = 2 * WIDTH;
    localparam int CW    = $clog2(HALF + 2);

    kar_state_t         state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   y_reg;
    logic [PRODW-1:0]   prod_reg;
    logic               done_reg;

    logic [1:0][WIDTH-1:0] z_half;
    logic [SW-1:0]      x_sum;
    logic [SW-1:0]      y_sum;
    logic [PW-1:0]      p_mcand_reg;
    logic [SW-1:0]      p_mplier_reg;
    logic [PW-1:0]      p_acc_reg;
    logic [PW-1:0]      z1;
    logic [PRODW-1:0]   comb_prod;

    // Unit 0 multiplies the low halves (z0), unit 1 the high halves (z2).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half_mul
            logic [WIDTH-1:0] mcand_reg;
            logic [HALF-1:0]  mplier_reg;
            logic [WIDTH-1:0] acc_reg;

            always_ff @(posedge clk) begin
                if (state_reg == KS_LOAD) begin
                    mcand_reg  <= WIDTH'(x_reg[gi*HALF +: HALF]);
                    mplier_reg <= y_reg[gi*HALF +: HALF];
                    acc_reg    <= '0;
                end else if (state_reg == KS_Z02) begin
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                end
            end

            assign z_half[gi] = acc_reg;
        end
    endgenerate

    assign x_sum = SW'(x_reg[HALF-1:0]) + SW'(x_reg[WIDTH-1:HALF]);
    assign y_sum = SW'(y_reg[HALF-1:0]) + SW'(y_reg[WIDTH-1:HALF]);

    always_ff @(posedge clk) begin
        if (state_reg == KS_LOAD) begin
            p_mcand_reg  <= PW'(x_sum);
            p_mplier_reg <= y_sum;
            p_acc_reg    <= '0;
        end else if (state_reg == KS_Z1) begin
            if (p_mplier_reg[0]) begin
                p_acc_reg <= p_acc_reg + p_mcand_reg;
            end
            p_mcand_reg  <= p_mcand_reg << 1;
            p_mplier_reg <= p_mplier_reg >> 1;
        end
    end

    // Middle term is never negative, so PW bits are enough for the subtraction.
    assign z1        = p_acc_reg - PW'(z_half[1]) - PW'(z_half[0]);
    assign comb_prod = {z_half[1], {WIDTH{1'b0}}}
                     + (PRODW'(z1) << HALF)
                     + PRODW'(z_half[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= KS_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                KS_IDLE: begin
                    if (go) begin
                        x_reg     <= x;
                        y_reg     <= y;
                        state_reg <= KS_LOAD;
                    end
                end
                KS_LOAD: begin
                    cnt_reg   <= '0;
                    state_reg <= KS_Z02;
                end
                KS_Z02: begin
                    if (cnt_reg == CW'(HALF - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= KS_Z1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                KS_Z1: begin
                    if (cnt_reg == CW'(HALF)) begin
                        cnt_reg   <= '0;
                        state_reg <= KS_COMB;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                KS_COMB: begin
                    prod_reg  <= comb_prod;
                    done_reg  <= 1'b1;
                    state_reg <= KS_DONE;
                end
                KS_DONE: begin
                    state_reg <= KS_IDLE;
                end
                default: begin
                    state_reg <= KS_IDLE;
                end
            endcase
        end
    end

    assign prod = prod_reg;
    assign done = done_reg;
    assign busy = (state_reg != KS_IDLE);

endmodule

// File: rtl/alu.sv
// 16-bit datapath ALU: registered single-cycle add/sub/address ops plus an
// iterative multiply whose result lands when the Karatsuba unit signals done.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);
    logic               launch;
    logic               kar_go;
    logic               kar_done;
    logic               kar_busy;
    logic [2*WIDTH-1:0] kar_prod;
    logic [WIDTH-1:0]   alu_next;
    logic [WIDTH-1:0]   result_reg;

    always_comb begin
        alu_next = '0;
        case (bus.opcode)
            OP_ADD, OP_LOAD, OP_STR: alu_next = bus.a + bus.b;
            OP_SUB:                  alu_next = bus.a - bus.b;
            default:                 alu_next = '0;
        endcase
    end

    // The multiplier stays busy through its done cycle, so a launch can never
    // collide with the product write-back.
    assign launch = bus.start && !kar_busy;
    assign kar_go = launch && (bus.opcode == OP_MUL);

    karatsuba_mul #(
        .WIDTH(WIDTH)
    ) kar (
        .clk  (clk),
        .rst  (rst),
        .go   (kar_go),
        .x    (bus.a),
        .y    (bus.b),
        .prod (kar_prod),
        .done (kar_done),
        .busy (kar_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
        end else if (kar_done) begin
            result_reg <= kar_prod[WIDTH-1:0];
        end else if (launch && (bus.opcode != OP_MUL)) begin
            result_reg <= alu_next;
        end
    end

    assign bus.result = result_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, busy/reset sequences and
// randomized ops checked against a plain-arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [W-1:0] model(logic [2:0] op, logic [W-1:0] x, logic [W-1:0] y);
        longint unsigned ax = longint'(x);
        longint unsigned by = longint'(y);
        longint unsigned r;
        case (op)
            OP_ADD, OP_LOAD, OP_STR: r = ax + by;
            OP_SUB:                  r = ax + 65536 - by;
            OP_MUL:                  r = ax * by;
            default:                 r = 0;
        endcase
        return W'(r % 65536);
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Issues one op; for MUL also checks hold, single done pulse and latency.
    // inject_k > 0 drives an ADD start that many cycles into a multiply.
    task automatic run_op(string name, logic [2:0] op, logic [W-1:0] x, logic [W-1:0] y,
                          logic [W-1:0] exp, int inject_k);
        logic [W-1:0] prior;
        int done_cnt;
        int first_k;
        bit hold_ok;
        @(negedge clk);
        prior      = bus.result;
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.a      = x;
        bus.b      = y;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.opcode = 3'($urandom_range(0, 7));
        bus.a      = W'($urandom);
        bus.b      = W'($urandom);
        if (op != OP_MUL) begin
            check(name, bus.result, exp);
        end else begin
            done_cnt = 0;
            first_k  = 0;
            hold_ok  = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                if (inject_k > 0 && k == inject_k) begin
                    bus.start  = 1'b1;
                    bus.opcode = OP_ADD;
                    bus.a      = 16'd1;
                    bus.b      = 16'd1;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                if (dut.kar.done) begin
                    done_cnt++;
                    if (first_k == 0) first_k = k;
                end
                if (k < 20 && bus.result !== prior) hold_ok = 1'b0;
            end
            bus.start = 1'b0;
            check(name, bus.result, exp);
            check({name, "_hold"}, W'(hold_ok), W'(1));
            check({name, "_done_pulses"}, W'(done_cnt), W'(1));
            check({name, "_latency"}, W'(first_k), W'(19));
        end
        $display("op=%03b a=0x%04h b=0x%04h result=0x%04h expected=0x%04h (%s)",
                 op, x, y, bus.result, exp, name);
    endtask

    initial begin
        int done_seen;
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{"add_28_22",  OP_ADD,  16'd28,     16'd22,     16'd50};
        vecs[1]  = '{"sub_6_8",    OP_SUB,  16'd6,      16'd8,      16'hFFFE};
        vecs[2]  = '{"load_10_32", OP_LOAD, 16'd10,     16'd32,     16'd42};
        vecs[3]  = '{"str_2_40",   OP_STR,  16'd2,      16'd40,     16'd42};
        vecs[4]  = '{"add_wrap",   OP_ADD,  16'hFFFF,   16'd1,      16'd0};
        vecs[5]  = '{"op011_zero", 3'b011,  16'd5,      16'd7,      16'd0};
        vecs[6]  = '{"mul_3_4",    OP_MUL,  16'd3,      16'd4,      16'd12};
        vecs[7]  = '{"mul_0_123",  OP_MUL,  16'd0,      16'd123,    16'd0};
        vecs[8]  = '{"mul_255sq",  OP_MUL,  16'd255,    16'd255,    16'd65025};
        vecs[9]  = '{"mul_10_20",  OP_MUL,  16'd10,     16'd20,     16'd200};
        vecs[10] = '{"mul_123_456",OP_MUL,  16'd123,    16'd456,    16'd56088};
        vecs[11] = '{"mul_ffff_sq",OP_MUL,  16'hFFFF,   16'hFFFF,   16'h0001};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = OP_ADD;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_result", bus.result, 16'd0);
        check("reset_busy", W'(dut.kar.busy), W'(0));
        check("reset_done", W'(dut.kar.done), W'(0));

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
        end

        // Result holds while start stays low.
        run_op("add_28_22_again", OP_ADD, 16'd28, 16'd22, 16'd50, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_50", bus.result, 16'd50);
        end

        // ADD issued mid-multiply is ignored.
        run_op("mul_busy_add", OP_MUL, 16'd10, 16'd20, 16'd200, 6);

        // Reset aborts a multiply: result clears, no done pulse, next MUL works.
        run_op("pre_abort_add", OP_ADD, 16'd100, 16'd1, 16'd101, 0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = OP_MUL;
        bus.a      = 16'd3;
        bus.b      = 16'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_result", bus.result, 16'd0);
        check("abort_busy", W'(dut.kar.busy), W'(0));
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (dut.kar.done) done_seen++;
        end
        check("abort_no_done", W'(done_seen), W'(0));
        check("abort_result_hold", bus.result, 16'd0);
        run_op("mul_after_abort", OP_MUL, 16'd123, 16'd456, 16'd56088, 0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.opcode = OP_ADD;
        bus.a      = 16'd5;
        bus.b      = 16'd5;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_over_start", bus.result, 16'd0);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            run_op("random", rop, ra, rb, model(rop, ra, rb), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
